// File: rtl/tl_drain.sv
// tl_drain: round-robin drain of four class FIFOs into one ready/valid word stream,
// with saturating per-channel word counters, counter readback and a sticky class-mismatch flag.
module tl_drain #(
    parameter int unsigned DW = 10,
    parameter int unsigned CW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable_i,
    input  logic          empty0_i,
    input  logic          empty1_i,
    input  logic          empty2_i,
    input  logic          empty3_i,
    input  logic [DW-1:0] data_in0_i,
    input  logic [DW-1:0] data_in1_i,
    input  logic [DW-1:0] data_in2_i,
    input  logic [DW-1:0] data_in3_i,
    output logic          pop0_o,
    output logic          pop1_o,
    output logic          pop2_o,
    output logic          pop3_o,
    output logic [DW-1:0] out_data_o,
    output logic [1:0]    out_chan_o,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    input  logic          req_i,
    input  logic [1:0]    idx_i,
    input  logic          clr_i,
    output logic [CW-1:0] cnt_out_o,
    output logic          cnt_valid_o,
    output logic          err_class_o
);

    localparam int unsigned NCH = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    last_q, last_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [1:0]    out_chan_q, out_chan_d;
    logic          out_valid_q, out_valid_d;
    logic [CW-1:0] cnt_q [NCH];
    logic [CW-1:0] cnt_d [NCH];
    logic          err_q, err_d;
    logic [CW-1:0] cnt_out_q, cnt_out_d;
    logic          cnt_valid_q, cnt_valid_d;

    logic [NCH-1:0] empty;
    logic [DW-1:0]  data_in [NCH];
    logic [1:0]     grant_c;
    logic           any_c;
    logic [1:0]     cand;
    logic [NCH-1:0] pop_c;
    logic           cap_c;

    assign empty      = {empty3_i, empty2_i, empty1_i, empty0_i};
    assign data_in[0] = data_in0_i;
    assign data_in[1] = data_in1_i;
    assign data_in[2] = data_in2_i;
    assign data_in[3] = data_in3_i;

    // First non-empty channel searching upward from the one after last served
    always_comb begin
        grant_c = last_q;
        any_c   = 1'b0;
        cand    = last_q;
        for (int unsigned k = 1; k <= NCH; k++) begin
            cand = last_q + 2'(k);
            if (!any_c && !empty[cand]) begin
                grant_c = cand;
                any_c   = 1'b1;
            end
        end
    end

    // Pop in IDLE, capture in WAIT, hold until accepted
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        pop_c       = '0;
        cap_c       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable_i && any_c) begin
                    pop_c[grant_c] = 1'b1;
                    last_d         = grant_c;
                    state_d        = S_WAIT;
                end
            end
            S_WAIT: begin
                out_data_d  = data_in[last_q];
                out_chan_d  = last_q;
                out_valid_d = 1'b1;
                cap_c       = 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (out_valid_q && out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // Reset must silence the strobes immediately, not at the next edge
    assign pop0_o = pop_c[0] & rst_n;
    assign pop1_o = pop_c[1] & rst_n;
    assign pop2_o = pop_c[2] & rst_n;
    assign pop3_o = pop_c[3] & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            last_q      <= 2'd3;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Counters, class check and readback; clr wins over a same-cycle capture
    always_comb begin
        cnt_d       = cnt_q;
        err_d       = err_q;
        cnt_out_d   = cnt_out_q;
        cnt_valid_d = req_i;
        if (req_i) begin
            cnt_out_d = cnt_q[idx_i];
        end
        if (clr_i) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt_d[i] = '0;
            end
            err_d = 1'b0;
        end else if (cap_c) begin
            if (cnt_q[last_q] != {CW{1'b1}}) begin
                cnt_d[last_q] = cnt_q[last_q] + CW'(1);
            end
            if (data_in[last_q][DW-1:DW-2] != last_q) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
            err_q       <= 1'b0;
            cnt_out_q   <= '0;
            cnt_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            cnt_out_q   <= cnt_out_d;
            cnt_valid_q <= cnt_valid_d;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_chan_o  = out_chan_q;
    assign out_valid_o = out_valid_q;
    assign cnt_out_o   = cnt_out_q;
    assign cnt_valid_o = cnt_valid_q;
    assign err_class_o = err_q;

endmodule

// File: tb/tb_tl_drain.sv
// Bench for tl_drain: emulated class FIFOs, a transaction-level reference model checked
// every cycle, a directed vector table, hand-written corner sequences and random traffic.
module tb_tl_drain;

    localparam int unsigned DW   = 10;
    localparam int unsigned CW   = 5;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [3:0]    empty_v;
    logic [DW-1:0] din [4];
    logic          pop0, pop1, pop2, pop3;
    logic [DW-1:0] out_data;
    logic [1:0]    out_chan;
    logic          out_valid;
    logic          out_ready;
    logic          req;
    logic [1:0]    idx;
    logic          clr;
    logic [CW-1:0] cnt_out;
    logic          cnt_valid;
    logic          err_class;

    always #5 clk = ~clk;

    tl_drain #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable),
        .empty0_i(empty_v[0]), .empty1_i(empty_v[1]), .empty2_i(empty_v[2]), .empty3_i(empty_v[3]),
        .data_in0_i(din[0]), .data_in1_i(din[1]), .data_in2_i(din[2]), .data_in3_i(din[3]),
        .pop0_o(pop0), .pop1_o(pop1), .pop2_o(pop2), .pop3_o(pop3),
        .out_data_o(out_data), .out_chan_o(out_chan), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .req_i(req), .idx_i(idx), .clr_i(clr),
        .cnt_out_o(cnt_out), .cnt_valid_o(cnt_valid), .err_class_o(err_class)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // FIFO contents held by the bench
    logic [DW-1:0] fq [4][$];

    // Reference model: transaction state, counters, sticky flag, readback
    int            last_m;
    bit            inflight, wait_m, valid_m, rb_pend, err_m;
    logic [DW-1:0] cur_word;
    int            cur_ch;
    int            cnt_m [4];
    logic [CW-1:0] cnt_out_m;

    // Values sampled at the falling edge
    logic [3:0]    pop_s;
    logic          s_valid, s_err, s_cnt_valid;
    logic [DW-1:0] s_data;
    logic [1:0]    s_chan;
    logic [CW-1:0] s_cnt_out;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        last_m    = 3;
        inflight  = 0;
        wait_m    = 0;
        valid_m   = 0;
        rb_pend   = 0;
        err_m     = 0;
        cnt_out_m = '0;
        cur_word  = '0;
        cur_ch    = 0;
        for (int c = 0; c < 4; c++) cnt_m[c] = 0;
    endtask

    task automatic mon();
        logic [3:0] pe;
        int gch;
        bit cap;
        pop_s       = {pop3, pop2, pop1, pop0};
        s_valid     = out_valid;
        s_data      = out_data;
        s_chan      = out_chan;
        s_err       = err_class;
        s_cnt_out   = cnt_out;
        s_cnt_valid = cnt_valid;
        cyc++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        chk("err_class", err_class, err_m);
        chk("cnt_valid", cnt_valid, rb_pend);
        chk("cnt_out", cnt_out, cnt_out_m);
        chk("out_valid", out_valid, valid_m);
        if (out_valid && valid_m) begin
            chk("out_data", out_data, cur_word);
            chk("out_chan", out_chan, cur_ch);
        end
        pe  = '0;
        gch = -1;
        if (!inflight && enable) begin
            for (int k = 1; k <= 4; k++) begin
                if (gch < 0 && !empty_v[(last_m + k) % 4]) gch = (last_m + k) % 4;
            end
        end
        if (gch >= 0) pe[gch] = 1'b1;
        chk("pop", pop_s, pe);
        rb_pend = req;
        if (req) cnt_out_m = CW'(cnt_m[idx]);
        cap = wait_m;
        if (clr) begin
            for (int c = 0; c < 4; c++) cnt_m[c] = 0;
            err_m = 0;
        end else if (cap) begin
            if (cnt_m[cur_ch] < CMAX) cnt_m[cur_ch]++;
            if (int'(cur_word[DW-1:DW-2]) != cur_ch) err_m = 1;
        end
        if (valid_m && out_ready) begin
            valid_m  = 0;
            inflight = 0;
        end
        wait_m = 0;
        if (cap) valid_m = 1;
        if (gch >= 0) begin
            inflight = 1;
            wait_m   = 1;
            cur_ch   = gch;
            cur_word = (fq[gch].size() > 0) ? fq[gch][0] : '0;
            last_m   = gch;
        end
    endtask

    task automatic fifo_update();
        for (int c = 0; c < 4; c++) begin
            if (pop_s[c] && fq[c].size() > 0) din[c] = fq[c].pop_front();
            empty_v[c] = (fq[c].size() == 0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
        fifo_update();
    endtask

    task automatic push(input int c, input logic [DW-1:0] w);
        fq[c].push_back(w);
        empty_v[c] = 1'b0;
    endtask

    task automatic wait_pop(input int c, output bit ok);
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            tick();
            if (pop_s[c]) ok = 1;
        end
    endtask

    task automatic drain();
        bit done;
        done   = 0;
        enable = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            tick();
            if (&empty_v && !inflight && !valid_m && !wait_m) done = 1;
        end
        chk("drain_timeout", done, 1);
        tick();
    endtask

    task automatic rd(input int i, input int exp);
        req = 1'b1;
        idx = 2'(i);
        tick();
        req = 1'b0;
        tick();
        chk("rd_valid", s_cnt_valid, 1);
        chk("rd_value", s_cnt_out, exp);
        tick();
        chk("rd_valid_drop", s_cnt_valid, 0);
    endtask

    typedef struct {
        int            ch;
        logic [DW-1:0] word;
        int            hold;
        logic [DW-1:0] exp_data;
        logic [1:0]    exp_chan;
        logic          exp_err;
    } vec_t;

    vec_t vt [6];
    int   exp_ord [5] = '{0, 1, 2, 3, 0};
    int   seen_ch [$];
    int   seen_cyc [$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int tcnt [4];
        logic [1:0] cls;

        rst_n     = 1'b0;
        enable    = 1'b1;
        empty_v   = 4'hF;
        out_ready = 1'b0;
        req       = 1'b0;
        idx       = 2'd0;
        clr       = 1'b0;
        for (int c = 0; c < 4; c++) din[c] = '0;
        model_reset();

        // Reset state
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_chan", out_chan, 0);
        chk("rst_cnt_out", cnt_out, 0);
        chk("rst_cnt_valid", cnt_valid, 0);
        chk("rst_err", err_class, 0);
        chk("rst_pops", {pop3, pop2, pop1, pop0}, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Round robin with every FIFO non-empty
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++)
            for (int j = 0; j < 2; j++) push(c, DW'({2'(c), 8'($urandom)}));
        for (int i = 0; i < 40 && seen_ch.size() < 5; i++) begin
            tick();
            for (int c = 0; c < 4; c++)
                if (pop_s[c]) begin
                    seen_ch.push_back(c);
                    seen_cyc.push_back(cyc);
                end
        end
        chk("rr_count", seen_ch.size(), 5);
        for (int i = 0; i < seen_ch.size() && i < 5; i++) begin
            chk("rr_order", seen_ch[i], exp_ord[i]);
            if (i > 0) chk("rr_spacing", seen_cyc[i] - seen_cyc[i-1], 3);
        end
        drain();

        // Directed single-word vectors
        vt[0] = '{2, 10'h2A5, 0, 10'h2A5, 2'd2, 1'b0};
        vt[1] = '{0, 10'h0F3, 5, 10'h0F3, 2'd0, 1'b0};
        vt[2] = '{1, 10'h155, 2, 10'h155, 2'd1, 1'b0};
        vt[3] = '{3, 10'h3C7, 0, 10'h3C7, 2'd3, 1'b0};
        vt[4] = '{0, 10'h300, 1, 10'h300, 2'd0, 1'b1};
        vt[5] = '{2, 10'h2AA, 0, 10'h2AA, 2'd2, 1'b1};
        for (int c = 0; c < 4; c++) tcnt[c] = 0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int v = 0; v < 6; v++) begin
            tcnt[vt[v].ch]++;
            out_ready = (vt[v].hold == 0);
            push(vt[v].ch, vt[v].word);
            wait_pop(vt[v].ch, ok);
            chk("vec_pop_seen", ok, 1);
            tick();
            chk("vec_wait_no_valid", s_valid, 0);
            tick();
            chk("vec_valid", s_valid, 1);
            chk("vec_data", s_data, vt[v].exp_data);
            chk("vec_chan", s_chan, vt[v].exp_chan);
            if (vt[v].hold > 0) begin
                for (int h = 2; h <= vt[v].hold; h++) begin
                    tick();
                    chk("vec_hold_valid", s_valid, 1);
                    chk("vec_hold_data", s_data, vt[v].exp_data);
                    chk("vec_hold_nopop", pop_s, 0);
                end
                out_ready = 1'b1;
                tick();
                chk("vec_accept_valid", s_valid, 1);
            end
            tick();
            chk("vec_valid_drop", s_valid, 0);
            chk("vec_err", s_err, vt[v].exp_err);
        end
        for (int c = 0; c < 4; c++) rd(c, tcnt[c]);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        chk("clr_err", s_err, 0);

        // Saturation after 33 words on channel 1
        for (int k = 0; k < 33; k++) push(1, DW'({2'b01, 8'(k)}));
        drain();
        rd(1, 31);
        chk("sat_err", s_err, 0);

        // Nothing to pop while all FIFOs are empty
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_nopop", pop_s, 0);
        end

        // Enable drops during WAIT: word completes, no further pops
        push(1, 10'h1B4);
        wait_pop(1, ok);
        chk("en_pop_seen", ok, 1);
        enable = 1'b0;
        tick();
        tick();
        chk("en_valid", s_valid, 1);
        chk("en_data", s_data, 10'h1B4);
        push(2, 10'h2C3);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("en_nopop", pop_s, 0);
        end
        drain();

        // Reset while holding a word
        out_ready = 1'b0;
        push(3, 10'h3AB);
        wait_pop(3, ok);
        chk("hr_pop_seen", ok, 1);
        tick();
        tick();
        chk("hr_valid", s_valid, 1);
        for (int c = 0; c < 4; c++) push(c, DW'({2'(c), 8'h5A}));
        rst_n = 1'b0;
        #1;
        chk("hr_out_valid", out_valid, 0);
        chk("hr_out_data", out_data, 0);
        chk("hr_cnt_out", cnt_out, 0);
        chk("hr_pops", {pop3, pop2, pop1, pop0}, 0);
        enable = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) rd(c, 0);
        enable    = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("hr_first_grant", pop_s, 4'b0001);
        drain();

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                int c;
                c = $urandom_range(0, 3);
                cls = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'(c);
                if (fq[c].size() < 4) push(c, DW'({cls, 8'($urandom)}));
            end
            enable    = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            req       = ($urandom_range(0, 3) == 0);
            idx       = 2'($urandom);
            clr       = ($urandom_range(0, 63) == 0);
            tick();
        end
        req       = 1'b0;
        clr       = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
